branch_predictor_bht: RTL and testbench
=======================================

# branch_predictor_bht

Parametrised dynamic branch predictor for the 5-stage MIPS pipeline. It replaces the single global 2-bit counter with three structures: an indexed pattern history table (PHT) of saturating counters, a tagged branch target buffer (BTB), and an optional global-history (gshare) mode. IF queries it combinationally every cycle with the fetch PC. ID reports each resolved BEQ/BNE back to it, and it keeps saturating hit and mispredict statistics.

## Interface
- IDX_W, 6: log2 of PHT/BTB entries (64 entries)
- TAG_W, 8: BTB tag width, taken from PC word-address bits above the index
- CNT_W, 2: PHT counter width, 2..4
- HIST_W, 6: global history length, ≤ IDX_W
- MODE, 0: 0 = bimodal (PC index), 1 = gshare (PC index XOR history)
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- stall  in  1  pipeline stall (I- or D-cache); freezes all state updates
- lk_pc  in  30  fetch PC word address (PC[31:2])
- lk_hit  out  1  BTB valid and tag match for lk_pc
- lk_taken  out  1  predicted taken
- lk_target  out  30  predicted target word address
- up_valid  in  1  resolved conditional branch in ID this cycle
- up_pc  in  30  word address of resolved branch
- up_taken  in  1  actual outcome
- up_target  in  30  actual taken target word address
- up_mispred  in  1  ID detected a wrong prediction for this branch
- st_updates  out  16  resolved-branch count, saturating
- st_mispreds  out  16  mispredict count, saturating

## Operation
- Index: `pidx = pc[IDX_W-1:0]`. In MODE 1, `gidx = pidx ^ {0, ghr}`, with the history zero-extended to IDX_W. In MODE 0, `gidx = pidx`.
- Tag: `pc[IDX_W+TAG_W-1:IDX_W]`.
- The BTB is indexed by pidx. The PHT is indexed by gidx.
- Lookup is purely combinational from the stored arrays and ghr:
  - lk_hit = valid[pidx] & (tag[pidx] == lk_pc tag)
  - lk_taken = lk_hit & PHT[gidx][CNT_W-1]
  - lk_target = target[pidx] when lk_hit, else lk_pc+1
- Update happens on the rising edge when up_valid & !stall. Indices are computed from up_pc and the current ghr, before the shift.
  - PHT counter: +1 if up_taken, saturating at 2^CNT_W-1; otherwise −1, saturating at 0.
  - BTB, when up_taken: valid=1, tag and target written. This allocates or overwrites an aliased entry.
  - BTB, when not taken: unchanged.
  - ghr (MODE 1 only): `ghr <= {ghr[HIST_W-2:0], up_taken}`. ghr is only ever updated non-speculatively.
  - st_updates increments by 1. st_mispreds increments by 1 if up_mispred. Both hold at 16'hFFFF.
- Reset values:
  - all PHT counters = 2^(CNT_W-1)−1 (weakly not-taken; 01 for CNT_W=2)
  - all valid bits = 0; tag and target = 0
  - ghr = 0; st_updates = st_mispreds = 0
  - consequence: lk_hit = lk_taken = 0 and lk_target = lk_pc+1

## Timing
- Lookup latency: 0 cycles (combinational).
- Update latency: 1 edge. A lookup in the cycle after the update sees the new state.
- Simultaneous lookup and update to the same entry: the lookup returns the pre-update value. There is no bypass.
- stall=1 with up_valid=1: the update is dropped, not queued. ID re-presents the branch while stalled and the update is taken on the first non-stalled cycle.
- up_mispred without up_valid: ignored.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous). The first update is accepted on the first edge after deassertion.
- Outputs are glitch-free only relative to lk_pc, ghr and array changes. There are no extra registers.

## Test plan
- Reset state: after reset, lk_pc=30'h40 → lk_hit=0, lk_taken=0, lk_target=30'h41. Both statistics counters read 0.
- Training, MODE 0:
  - Three taken updates for pc=30'h10, target=30'h80 → lk_taken=1, lk_target=30'h80.
  - Then three not-taken updates → lk_taken=0 and lk_hit stays 1.
  - Counter saturates at 3 and then at 0; verified via the flip points.
- Tag alias: train pc=30'h05, then a taken update for pc=30'h05+(1<<IDX_W) → lk_hit for 30'h05 = 0 and for the alias = 1.
- Gshare, MODE 1, HIST_W=2: alternate T/N updates at pc=30'h20 for 20 iterations, then count mispreds on the next 8 (mispred driven from lk_taken ≠ outcome) → 0. In MODE 0 the same sequence mispredicts ≥4 of those 8.
- Stall: update with stall=1 → no change in counters, BTB, ghr or stats. Release stall with the update held → exactly one increment.
- Statistics saturation: 65540 mispredicted updates → st_updates = st_mispreds = 16'hFFFF, with no wrap.

Source files
------------

// File: rtl/branch_predictor_bht.sv
// Dynamic branch predictor: PHT of saturating counters, tagged BTB and optional gshare history.
// Lookup is combinational from the stored state; resolved branches from ID update it on the clock edge.
module branch_predictor_bht #(
   parameter int unsigned IDX_W  = 6,
   parameter int unsigned TAG_W  = 8,
   parameter int unsigned CNT_W  = 2,
   parameter int unsigned HIST_W = 6,
   parameter int unsigned MODE   = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic [29:0] lk_pc,
   output logic        lk_hit,
   output logic        lk_taken,
   output logic [29:0] lk_target,
   input  logic        up_valid,
   input  logic [29:0] up_pc,
   input  logic        up_taken,
   input  logic [29:0] up_target,
   input  logic        up_mispred,
   output logic [15:0] st_updates,
   output logic [15:0] st_mispreds
);

   localparam int unsigned PC_W  = 30;
   localparam int unsigned ST_W  = 16;
   localparam int unsigned N_ENT = 1 << IDX_W;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((1 << (CNT_W - 1)) - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [ST_W-1:0]  ST_MAX   = '1;

   logic [CNT_W-1:0]  r_pht    [N_ENT];
   logic              r_valid  [N_ENT];
   logic [TAG_W-1:0]  r_tag    [N_ENT];
   logic [PC_W-1:0]   r_target [N_ENT];
   logic [HIST_W-1:0] r_ghr;
   logic [ST_W-1:0]   r_st_updates;
   logic [ST_W-1:0]   r_st_mispreds;

   logic [IDX_W-1:0] w_lk_pidx;
   logic [IDX_W-1:0] w_lk_gidx;
   logic [TAG_W-1:0] w_lk_tag;
   logic [IDX_W-1:0] w_up_pidx;
   logic [IDX_W-1:0] w_up_gidx;
   logic [TAG_W-1:0] w_up_tag;
   logic [CNT_W-1:0] w_up_cnt;
   logic [CNT_W-1:0] w_up_cnt_nxt;
   logic             w_up_en;
   logic             w_unused;

   // Index/tag extraction; history is zero-extended into the low index bits in gshare mode
   assign w_lk_pidx = lk_pc[IDX_W-1:0];
   assign w_lk_tag  = lk_pc[IDX_W+TAG_W-1:IDX_W];
   assign w_lk_gidx = (MODE == 1) ? (w_lk_pidx ^ IDX_W'(r_ghr)) : w_lk_pidx;
   assign w_up_pidx = up_pc[IDX_W-1:0];
   assign w_up_tag  = up_pc[IDX_W+TAG_W-1:IDX_W];
   assign w_up_gidx = (MODE == 1) ? (w_up_pidx ^ IDX_W'(r_ghr)) : w_up_pidx;
   assign w_unused  = ^{lk_pc[PC_W-1:IDX_W+TAG_W], up_pc[PC_W-1:IDX_W+TAG_W]};

   assign lk_hit    = r_valid[w_lk_pidx] && (r_tag[w_lk_pidx] == w_lk_tag);
   assign lk_taken  = lk_hit && r_pht[w_lk_gidx][CNT_W-1];
   assign lk_target = lk_hit ? r_target[w_lk_pidx] : (lk_pc + PC_W'(1));

   assign st_updates  = r_st_updates;
   assign st_mispreds = r_st_mispreds;

   assign w_up_en  = up_valid && !stall;
   assign w_up_cnt = r_pht[w_up_gidx];

   // Saturating counter step toward the resolved outcome
   always_comb begin
      w_up_cnt_nxt = w_up_cnt;
      if (up_taken) begin
         if (w_up_cnt != CNT_MAX) w_up_cnt_nxt = w_up_cnt + CNT_W'(1);
      end else begin
         if (w_up_cnt != '0) w_up_cnt_nxt = w_up_cnt - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < N_ENT; i++) begin
            r_pht[i]    <= CNT_INIT;
            r_valid[i]  <= 1'b0;
            r_tag[i]    <= '0;
            r_target[i] <= '0;
         end
      end else if (w_up_en) begin
         r_pht[w_up_gidx] <= w_up_cnt_nxt;
         // Taken branches allocate, or overwrite an aliased entry
         if (up_taken) begin
            r_valid[w_up_pidx]  <= 1'b1;
            r_tag[w_up_pidx]    <= w_up_tag;
            r_target[w_up_pidx] <= up_target;
         end
      end
   end

   // History and statistics are only advanced by accepted, non-speculative updates
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ghr         <= '0;
         r_st_updates  <= '0;
         r_st_mispreds <= '0;
      end else if (w_up_en) begin
         if (MODE == 1) r_ghr <= HIST_W'({r_ghr, up_taken});
         if (r_st_updates != ST_MAX) r_st_updates <= r_st_updates + ST_W'(1);
         if (up_mispred && (r_st_mispreds != ST_MAX)) r_st_mispreds <= r_st_mispreds + ST_W'(1);
      end
   end

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Bench for branch_predictor_bht: a bimodal and a gshare (HIST_W=2) instance share stimulus and
// are compared to an array-based reference model, fixed vectors and hand-built corner sequences.
module tb_branch_predictor_bht;

   logic        clk, rst_n, stall, up_valid, up_taken, mp_b, mp_g;
   logic [29:0] lk_pc, up_pc, up_target;
   logic        hit_b, tk_b, hit_g, tk_g;
   logic [29:0] tg_b, tg_g;
   logic [15:0] su_b, sm_b, su_g, sm_g;

   branch_predictor_bht #(.IDX_W(6), .TAG_W(8), .CNT_W(2), .HIST_W(6), .MODE(0)) u_bim (
      .clk(clk), .rst_n(rst_n), .stall(stall), .lk_pc(lk_pc),
      .lk_hit(hit_b), .lk_taken(tk_b), .lk_target(tg_b),
      .up_valid(up_valid), .up_pc(up_pc), .up_taken(up_taken), .up_target(up_target),
      .up_mispred(mp_b), .st_updates(su_b), .st_mispreds(sm_b));

   branch_predictor_bht #(.IDX_W(6), .TAG_W(8), .CNT_W(2), .HIST_W(2), .MODE(1)) u_gsh (
      .clk(clk), .rst_n(rst_n), .stall(stall), .lk_pc(lk_pc),
      .lk_hit(hit_g), .lk_taken(tk_g), .lk_target(tg_g),
      .up_valid(up_valid), .up_pc(up_pc), .up_taken(up_taken), .up_target(up_target),
      .up_mispred(mp_g), .st_updates(su_g), .st_mispreds(sm_g));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_pass = 0;
   int n_total = 0;
   int obs_mb, obs_mg;

   // Reference model: instance 0 = bimodal, instance 1 = gshare with 2 history bits
   int          m_pht [2][64];
   bit          m_val [2][64];
   int          m_tag [2][64];
   logic [29:0] m_tgt [2][64];
   int          m_ghr [2];
   int          m_upd [2];
   int          m_mis [2];

   function automatic void model_reset();
      for (int m = 0; m < 2; m++) begin
         for (int i = 0; i < 64; i++) begin
            m_pht[m][i] = 1; m_val[m][i] = 0; m_tag[m][i] = 0; m_tgt[m][i] = '0;
         end
         m_ghr[m] = 0; m_upd[m] = 0; m_mis[m] = 0;
      end
   endfunction

   // Returns {hit, taken, target}
   function automatic logic [31:0] model_lookup(input int m, input logic [29:0] pc);
      int idx, g, tg;
      logic hit, tk;
      logic [29:0] t;
      idx = int'(pc % 30'd64);
      tg  = int'((pc / 30'd64) % 30'd256);
      g   = (m == 1) ? (idx ^ (m_ghr[m] % 4)) : idx;
      hit = m_val[m][idx] && (m_tag[m][idx] == tg);
      tk  = hit && (m_pht[m][g] >= 2);
      t   = hit ? m_tgt[m][idx] : pc + 30'd1;
      return {hit, tk, t};
   endfunction

   function automatic void model_update(input int m, input logic mp);
      int idx, g;
      idx = int'(up_pc % 30'd64);
      g   = (m == 1) ? (idx ^ (m_ghr[m] % 4)) : idx;
      if (up_taken) begin
         if (m_pht[m][g] < 3) m_pht[m][g]++;
         m_val[m][idx] = 1;
         m_tag[m][idx] = int'((up_pc / 30'd64) % 30'd256);
         m_tgt[m][idx] = up_target;
      end else if (m_pht[m][g] > 0) begin
         m_pht[m][g]--;
      end
      if (m == 1) m_ghr[m] = (m_ghr[m] * 2 + int'(up_taken)) % 4;
      if (m_upd[m] < 65535) m_upd[m]++;
      if (mp && m_mis[m] < 65535) m_mis[m]++;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
   endtask

   task automatic check_lookup(input string nm);
      chk({nm, "_bim"}, 64'({hit_b, tk_b, tg_b}), 64'(model_lookup(0, lk_pc)));
      chk({nm, "_gsh"}, 64'({hit_g, tk_g, tg_g}), 64'(model_lookup(1, lk_pc)));
   endtask

   task automatic check_stats(input string nm);
      chk({nm, "_stats_bim"}, 64'({su_b, sm_b}), 64'({16'(m_upd[0]), 16'(m_mis[0])}));
      chk({nm, "_stats_gsh"}, 64'({su_g, sm_g}), 64'({16'(m_upd[1]), 16'(m_mis[1])}));
   endtask

   // One clock: the model follows the edge when the DUT would accept an update
   task automatic cycle();
      @(posedge clk);
      if (rst_n && up_valid && !stall) begin
         model_update(0, mp_b);
         model_update(1, mp_g);
      end
      @(negedge clk);
   endtask

   // Single resolved branch; mispredict is derived from the model, observed mispredicts from the DUT
   task automatic upd(input logic [29:0] pc, input logic tk, input logic [29:0] tgt);
      logic [31:0] pb, pg;
      lk_pc = pc; up_pc = pc; up_taken = tk; up_target = tgt; up_valid = 1'b1; stall = 1'b0;
      pb = model_lookup(0, pc);
      pg = model_lookup(1, pc);
      mp_b = (pb[30] != tk);
      mp_g = (pg[30] != tk);
      #1;
      if (tk_b != tk) obs_mb++;
      if (tk_g != tk) obs_mg++;
      cycle();
      up_valid = 1'b0; mp_b = 1'b0; mp_g = 1'b0;
   endtask

   typedef struct {
      bit          do_upd;
      logic [29:0] pc;
      bit          taken;
      logic [29:0] tgt;
      logic [29:0] lpc;
      bit          e_hit;
      bit          e_taken;
      logic [29:0] e_tgt;
   } vec_t;

   vec_t tbl [13];

   initial begin
      int cnt_before;
      // Bimodal expectations: counter at pc 0x10 starts at 1, saturates at 3 and at 0
      tbl[0]  = '{0, 30'h00, 0, 30'h000, 30'h11, 0, 0, 30'h012};
      tbl[1]  = '{1, 30'h10, 1, 30'h080, 30'h10, 1, 1, 30'h080};
      tbl[2]  = '{1, 30'h10, 1, 30'h080, 30'h10, 1, 1, 30'h080};
      tbl[3]  = '{1, 30'h10, 1, 30'h080, 30'h10, 1, 1, 30'h080};
      tbl[4]  = '{1, 30'h10, 0, 30'h000, 30'h10, 1, 1, 30'h080};
      tbl[5]  = '{1, 30'h10, 0, 30'h000, 30'h10, 1, 0, 30'h080};
      tbl[6]  = '{1, 30'h10, 0, 30'h000, 30'h10, 1, 0, 30'h080};
      tbl[7]  = '{1, 30'h10, 0, 30'h000, 30'h10, 1, 0, 30'h080};
      tbl[8]  = '{1, 30'h10, 1, 30'h090, 30'h10, 1, 0, 30'h090};
      tbl[9]  = '{1, 30'h10, 1, 30'h090, 30'h10, 1, 1, 30'h090};
      tbl[10] = '{1, 30'h05, 1, 30'h100, 30'h05, 1, 1, 30'h100};
      tbl[11] = '{1, 30'h45, 1, 30'h200, 30'h05, 0, 0, 30'h006};
      tbl[12] = '{0, 30'h00, 0, 30'h000, 30'h45, 1, 1, 30'h200};

      rst_n = 1'b0; stall = 1'b0; up_valid = 1'b0; up_taken = 1'b0; mp_b = 1'b0; mp_g = 1'b0;
      lk_pc = '0; up_pc = '0; up_target = '0;
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      lk_pc = 30'h40;
      #1;
      chk("reset_lookup_bim", 64'({hit_b, tk_b, tg_b}), 64'({1'b0, 1'b0, 30'h41}));
      chk("reset_lookup_gsh", 64'({hit_g, tk_g, tg_g}), 64'({1'b0, 1'b0, 30'h41}));
      chk("reset_stats", 64'({su_b, sm_b, su_g, sm_g}), 64'(0));

      for (int i = 0; i < 13; i++) begin
         if (tbl[i].do_upd) upd(tbl[i].pc, tbl[i].taken, tbl[i].tgt);
         lk_pc = tbl[i].lpc;
         #1;
         chk($sformatf("vec%0d", i), 64'({hit_b, tk_b, tg_b}),
             64'({tbl[i].e_hit, tbl[i].e_taken, tbl[i].e_tgt}));
         check_lookup($sformatf("vec%0d_model", i));
      end
      check_stats("vec");

      // Alternating pattern: gshare learns it, bimodal keeps flipping
      for (int i = 0; i < 20; i++) upd(30'h20, (i % 2) == 0, 30'h2A0);
      obs_mb = 0; obs_mg = 0;
      for (int i = 0; i < 8; i++) upd(30'h20, (i % 2) == 0, 30'h2A0);
      chk("gshare_alt_mispreds", 64'(obs_mg), 64'(0));
      chk("bimodal_alt_mispreds_ge4", 64'(obs_mb >= 4), 64'(1));
      check_stats("alt");

      // Stalled update is dropped while held, accepted once on release
      cnt_before = m_upd[0];
      lk_pc = 30'h30; up_pc = 30'h30; up_taken = 1'b1; up_target = 30'h99;
      up_valid = 1'b1; stall = 1'b1; mp_b = 1'b1; mp_g = 1'b1;
      cycle(); cycle();
      #1;
      chk("stall_no_alloc", 64'({hit_b, hit_g}), 64'(0));
      check_stats("stall_held");
      stall = 1'b0;
      cycle();
      up_valid = 1'b0; mp_b = 1'b0; mp_g = 1'b0;
      #1;
      chk("stall_release_alloc", 64'({hit_b, tg_b}), 64'({1'b1, 30'h99}));
      chk("stall_release_once", 64'(su_b), 64'(cnt_before + 1));
      check_stats("stall_rel");

      // Mispredict flag without a valid update must not count
      mp_b = 1'b1; mp_g = 1'b1;
      cycle();
      mp_b = 1'b0; mp_g = 1'b0;
      check_stats("mp_no_valid");

      // Random traffic over a small PC range so entries alias and collide with lookups
      for (int i = 0; i < 1500; i++) begin
         lk_pc     = 30'($urandom_range(0, 255));
         up_pc     = ($urandom % 4 == 0) ? lk_pc : 30'($urandom_range(0, 255));
         up_taken  = 1'($urandom % 2);
         up_target = 30'($urandom);
         up_valid  = ($urandom % 8) != 0;
         stall     = ($urandom % 6) == 0;
         mp_b      = 1'($urandom % 2);
         mp_g      = mp_b;
         #1;
         check_lookup("rand");
         cycle();
         if (i % 50 == 0) check_stats("rand");
      end
      up_valid = 1'b0; stall = 1'b0; mp_b = 1'b0; mp_g = 1'b0;
      check_stats("rand_end");

      // Asynchronous reset in the middle of a cycle
      upd(30'h33, 1'b1, 30'h1234);
      #2;
      rst_n = 1'b0;
      lk_pc = 30'h33;
      #1;
      chk("async_rst_lookup", 64'({hit_b, tk_b, tg_b, hit_g}), 64'({1'b0, 1'b0, 30'h34, 1'b0}));
      chk("async_rst_stats", 64'({su_b, sm_b, su_g, sm_g}), 64'(0));
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      upd(30'h33, 1'b1, 30'h4321);
      #1;
      chk("post_rst_first_upd", 64'({hit_b, tg_b, su_b}), 64'({1'b1, 30'h4321, 16'd1}));
      check_lookup("post_rst");

      // Statistics saturate at 16'hFFFF without wrapping
      up_pc = 30'h3FF; up_taken = 1'b1; up_target = 30'h7; up_valid = 1'b1; stall = 1'b0;
      mp_b = 1'b1; mp_g = 1'b1;
      for (int i = 0; i < 65540; i++) cycle();
      up_valid = 1'b0; mp_b = 1'b0; mp_g = 1'b0;
      chk("sat_bim", 64'({su_b, sm_b}), 64'({16'hFFFF, 16'hFFFF}));
      chk("sat_gsh", 64'({su_g, sm_g}), 64'({16'hFFFF, 16'hFFFF}));
      check_stats("sat");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
